// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl: pops num_words rows from the output FIFO and
// issues one SRAM write per row, tracking the FIFO read latency.
module ofifo_drain_ctrl #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              o_valid,
    input  logic              o_full,
    output logic              rd,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              full_stall
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  written_q, written_d;
    logic [RD_LAT-1:0] wpipe_q, wpipe_d;
    logic              aborted_q, aborted_d;
    logic              fstall_q, fstall_d;
    logic              issue;
    logic              wr_fire;
    logic [ADDR_W-1:0] wr_addr;

    // Write pipe: a popped row lands on the SRAM RD_LAT cycles later.
    if (RD_LAT == 1) begin : g_lat1
        assign wpipe_d = issue;
    end else begin : g_latn
        assign wpipe_d = {wpipe_q[RD_LAT-2:0], issue};
    end

    assign wr_fire = wpipe_q[RD_LAT-1];
    assign wr_addr = base_q + ADDR_W'(written_q);

    // Next-state and pop/write control.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        issued_d  = issued_q;
        written_d = written_q;
        addr_d    = addr_q;
        aborted_d = aborted_q;
        fstall_d  = fstall_q;
        rd        = 1'b0;
        issue     = 1'b0;

        if (wr_fire) begin
            written_d = written_q + CNT_ONE;
            addr_d    = wr_addr;
        end

        unique case (state_q)
            IDLE: begin
                if (o_full) begin
                    fstall_d = 1'b1;
                end
                if (start) begin
                    base_d    = base_addr;
                    num_d     = num_words;
                    aborted_d = 1'b0;
                    fstall_d  = 1'b0;
                    issued_d  = '0;
                    written_d = '0;
                    state_d   = (num_words == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                rd    = o_valid & (issued_q < num_q) & ~abort;
                issue = rd & o_valid;
                if (issue) begin
                    issued_d = issued_q + CNT_ONE;
                end
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FLUSH;
                end else if (issued_q == num_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (wpipe_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers; reset drops any in-flight write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            num_q     <= '0;
            issued_q  <= '0;
            written_q <= '0;
            addr_q    <= '0;
            wpipe_q   <= '0;
            aborted_q <= 1'b0;
            fstall_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            num_q     <= num_d;
            issued_q  <= issued_d;
            written_q <= written_d;
            addr_q    <= addr_d;
            wpipe_q   <= wpipe_d;
            aborted_q <= aborted_d;
            fstall_q  <= fstall_d;
        end
    end

    assign sram_cen   = ~wr_fire;
    assign sram_wen   = ~wr_fire;
    assign sram_addr  = wr_fire ? wr_addr : addr_q;
    assign busy       = (state_q == DRAIN) || (state_q == FLUSH);
    assign done       = (state_q == DONE);
    assign aborted    = aborted_q;
    assign full_stall = fstall_q;

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// tb_ofifo_drain_ctrl: randomized drains against a cycle-level
// reference model, with a scoreboard monitor on writes and done.
module tb_ofifo_drain_ctrl;

    localparam int LAT  = 1;
    localparam int MAXC = 20000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [10:0] base_addr;
    logic [10:0] num_words;
    logic        o_valid;
    logic        o_full;
    logic        rd;
    logic        sram_cen;
    logic        sram_wen;
    logic [10:0] sram_addr;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        full_stall;

    ofifo_drain_ctrl #(
        .ADDR_W(11),
        .CNT_W (11),
        .RD_LAT(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .num_words (num_words),
        .o_valid   (o_valid),
        .o_full    (o_full),
        .rd        (rd),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .full_stall(full_stall)
    );

    typedef struct {
        int          c;
        logic [10:0] a;
    } wr_t;

    typedef struct {
        int c;
        bit ab;
    } dn_t;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  exp_rd[MAXC];
    bit  exp_fs[MAXC];
    bit  exp_ab[MAXC];
    bit  fs_m   = 1'b0;
    bit  ab_m   = 1'b0;
    wr_t wq[$];
    dn_t dq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input bit er);
        if (cyc < MAXC) begin
            exp_rd[cyc] = er;
            exp_fs[cyc] = fs_m;
            exp_ab[cyc] = ab_m;
        end
    endtask

    task automatic rst_vals(input string tag);
        chk({tag, "_rd"}, int'(rd), 0);
        chk({tag, "_cen"}, int'(sram_cen), 1);
        chk({tag, "_wen"}, int'(sram_wen), 1);
        chk({tag, "_addr"}, int'(sram_addr), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_aborted"}, int'(aborted), 0);
        chk({tag, "_fstall"}, int'(full_stall), 0);
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin : mon
        wr_t w;
        dn_t d;
        if (mon_en && cyc < MAXC) begin
            chk("rd", int'(rd), int'(exp_rd[cyc]));
            chk("full_stall", int'(full_stall), int'(exp_fs[cyc]));
            chk("aborted", int'(aborted), int'(exp_ab[cyc]));
            chk("wen_eq_cen", int'(sram_wen), int'(sram_cen));
            if (!sram_cen) begin
                chk("write_expected", int'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("wr_cycle", cyc, w.c);
                    chk("wr_addr", int'(sram_addr), int'(w.a));
                end
            end
            if (done) begin
                chk("done_expected", int'(dq.size() > 0), 1);
                if (dq.size() > 0) begin
                    d = dq.pop_front();
                    chk("done_cycle", cyc, d.c);
                    chk("done_aborted", int'(aborted), int'(d.ab));
                end
            end
        end
    end

    task automatic idle(input int n, input bit force_full);
        for (int i = 0; i < n; i++) begin
            start   = 1'b0;
            abort   = 1'($urandom);
            o_valid = 1'($urandom);
            o_full  = force_full ? 1'b1 : ($urandom_range(0, 3) == 0);
            rec(1'b0);
            if (o_full) fs_m = 1'b1;
            step();
        end
    endtask

    // vmode: 0 valid always, 1 random valid, 2 pattern 1,0,0,1,1 then 1.
    task automatic drain(input logic [10:0] b, input int n,
                         input int ab_at, input int vmode);
        int t0;
        int e;
        int f;
        int d;
        int iss;
        int last;
        int j;
        bit ov;
        bit ab;
        bit er;
        logic [4:0] pat;
        pat = 5'b11001;
        start     = 1'b1;
        base_addr = b;
        num_words = 11'(n);
        o_valid   = 1'($urandom);
        o_full    = 1'b0;
        abort     = 1'b0;
        rec(1'b0);
        fs_m = 1'b0;
        ab_m = 1'b0;
        t0 = cyc;
        step();
        if (n == 0) begin
            d = t0 + 1;
        end else begin
            iss  = 0;
            last = -1;
            j    = 0;
            e    = -1;
            while (e < 0) begin
                case (vmode)
                    0:       ov = 1'b1;
                    2:       ov = (j < 5) ? pat[j] : 1'b1;
                    default: ov = ($urandom_range(0, 3) != 0);
                endcase
                ab = (ab_at >= 0) && (iss == ab_at);
                er = ov && (iss < n) && !ab;
                start     = 1'($urandom);
                base_addr = 11'($urandom);
                num_words = 11'($urandom);
                o_valid   = ov;
                o_full    = 1'($urandom);
                abort     = ab;
                rec(er);
                if (iss == n || ab || j > 400) e = cyc;
                if (ab) ab_m = 1'b1;
                if (er) begin
                    wq.push_back('{c: cyc + LAT, a: b + 11'(iss)});
                    iss++;
                    last = cyc;
                end
                j++;
                step();
            end
            f = e + 1;
            if (last >= 0 && last + LAT + 1 > f) f = last + LAT + 1;
            d = f + 1;
        end
        dq.push_back('{c: d, ab: ab_m});
        while (cyc <= d) begin
            start   = 1'b0;
            abort   = 1'($urandom);
            o_valid = 1'($urandom);
            o_full  = 1'($urandom);
            rec(1'b0);
            step();
        end
    endtask

    initial begin
        int n;
        int aat;
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        o_valid   = 1'b0;
        o_full    = 1'b0;
        base_addr = '0;
        num_words = '0;
        #2;
        rst_vals("reset");
        step();
        step();
        reset  = 1'b1;
        mon_en = 1'b1;

        idle(2, 1'b1);
        drain(11'h010, 4, -1, 0);
        idle(2, 1'b0);
        drain(11'h123, 3, -1, 2);
        idle(1, 1'b1);
        drain(11'h7FE, 4, -1, 0);
        idle(1, 1'b0);
        drain(11'h200, 10, 3, 0);
        idle(1, 1'b0);
        drain(11'h055, 0, -1, 1);
        idle(1, 1'b0);
        drain(11'h300, 5, 4, 0);
        drain(11'h400, 6, 0, 1);

        for (int k = 0; k < 40; k++) begin
            idle($urandom_range(0, 3), 1'b0);
            n   = $urandom_range(0, 12);
            aat = (n > 0 && $urandom_range(0, 3) == 0) ?
                  $urandom_range(0, n - 1) : -1;
            drain(11'($urandom), n, aat, $urandom_range(0, 2));
        end
        idle(3, 1'b0);
        chk("wq_drained", wq.size(), 0);
        chk("dq_drained", dq.size(), 0);

        mon_en    = 1'b0;
        start     = 1'b1;
        base_addr = 11'h100;
        num_words = 11'd8;
        o_valid   = 1'b1;
        o_full    = 1'b0;
        abort     = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_rst_rd", int'(rd), 1);
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        rst_vals("midrst");
        step();
        reset = 1'b1;
        step();
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_cen", int'(sram_cen), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
